// File: rtl/aclk_pkg.sv
// Shared types, limits and BCD helpers for the alarm clock time datapath.
// Used by the time-of-day counter, the hour formatter and the alarm
// register logic.
package aclk_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       MAX_LS     = 4'd9;
  localparam bcd_t       MAX_MS_MIN = 4'd5;
  localparam logic [7:0] MAX_HR     = 8'd23;
  localparam logic [7:0] NOON_HR    = 8'd12;

  // Two-digit BCD from a small binary value; out-of-range tens truncate.
  function automatic logic [7:0] bin2bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

  // Binary value of a two-digit BCD field (handles non-BCD digits too).
  function automatic logic [7:0] bcd2bin(input bcd_t ms, input bcd_t ls);
    return (8'(ms) * 8'd10) + 8'(ls);
  endfunction

  // True when the digits form a legal 24-hour time; seconds are only
  // inspected when check_sec is set.
  function automatic logic bcd_time_valid(input bcd_t ms_hr, input bcd_t ls_hr,
                                          input bcd_t ms_min, input bcd_t ls_min,
                                          input bcd_t ms_sec, input bcd_t ls_sec,
                                          input logic check_sec);
    logic ok;
    ok = (ls_hr <= MAX_LS) && (ls_min <= MAX_LS) &&
         (bcd2bin(ms_hr, ls_hr) <= MAX_HR) && (ms_min <= MAX_MS_MIN);
    if (check_sec) begin
      ok = ok && (ls_sec <= MAX_LS) && (ms_sec <= MAX_MS_MIN);
    end
    return ok;
  endfunction

endpackage

// File: rtl/aclk_hr_fmt.sv
// Combinational hour formatter: turns a 24-hour BCD hour into either the
// same 24-hour digits or a 12-hour value with a PM flag. Shared with the
// alarm display path.
module aclk_hr_fmt
  import aclk_pkg::*;
(
  input  logic [3:0] ms_hr,
  input  logic [3:0] ls_hr,
  input  logic       mode_12h,
  output logic [3:0] disp_ms_hr,
  output logic [3:0] disp_ls_hr,
  output logic       disp_pm
);

  logic [7:0] hr_bin;
  logic [7:0] hr_pm_bcd;

  assign hr_bin = bcd2bin(ms_hr, ls_hr);

  // Map 00 -> 12 AM, 12 -> 12 PM and 13..23 -> 01..11 PM in 12-hour mode.
  always_comb begin
    disp_ms_hr = ms_hr;
    disp_ls_hr = ls_hr;
    disp_pm    = 1'b0;
    hr_pm_bcd  = bin2bcd(32'(hr_bin - NOON_HR));
    if (mode_12h) begin
      if (hr_bin == 8'd0) begin
        disp_ms_hr = 4'd1;
        disp_ls_hr = 4'd2;
      end else if (hr_bin < NOON_HR) begin
        disp_ms_hr = ms_hr;
        disp_ls_hr = ls_hr;
      end else if (hr_bin == NOON_HR) begin
        disp_ms_hr = 4'd1;
        disp_ls_hr = 4'd2;
        disp_pm    = 1'b1;
      end else begin
        disp_ms_hr = hr_pm_bcd[7:4];
        disp_ls_hr = hr_pm_bcd[3:0];
        disp_pm    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aclk_time_counter.sv
// BCD time-of-day counter for the alarm clock. Counts HH:MM:SS (or HH:MM
// when CNT_SECONDS=0) in 24-hour form, supports load, hold and rollover
// strobes, and exposes a 12/24-hour hour view.
// Optional build macro ACLK_CNT_LOAD_CHECK_EN adds a registered load_err
// output and rejects out-of-range load values.
module aclk_time_counter
  import aclk_pkg::*;
#(
  parameter int CNT_SECONDS = 1,
  parameter int RESET_HR    = 0,
  parameter int RESET_MIN   = 0
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       hold,
  input  logic       load_new_c,
  input  logic [3:0] new_time_ms_hr,
  input  logic [3:0] new_time_ls_hr,
  input  logic [3:0] new_time_ms_min,
  input  logic [3:0] new_time_ls_min,
  input  logic [3:0] new_time_ms_sec,
  input  logic [3:0] new_time_ls_sec,
  input  logic       mode_12h,
  output logic [3:0] time_ms_hr,
  output logic [3:0] time_ls_hr,
  output logic [3:0] time_ms_min,
  output logic [3:0] time_ls_min,
  output logic [3:0] time_ms_sec,
  output logic [3:0] time_ls_sec,
  output logic [3:0] disp_ms_hr,
  output logic [3:0] disp_ls_hr,
  output logic       disp_pm,
  output logic       min_tick,
  output logic       day_tick
`ifdef ACLK_CNT_LOAD_CHECK_EN
  ,
  output logic       load_err
`endif
);

  localparam logic [7:0] RESET_HR_BCD  = bin2bcd(RESET_HR);
  localparam logic [7:0] RESET_MIN_BCD = bin2bcd(RESET_MIN);
  localparam logic       HAS_SECONDS   = (CNT_SECONDS != 0);

  bcd_t ms_hr_q, ls_hr_q, ms_min_q, ls_min_q, ms_sec_q, ls_sec_q;
  bcd_t ms_hr_d, ls_hr_d, ms_min_d, ls_min_d, ms_sec_d, ls_sec_d;
  logic min_tick_q, min_tick_d;
  logic day_tick_q, day_tick_d;
  logic min_adv;
  logic hr_adv;
  logic load_ok;
`ifdef ACLK_CNT_LOAD_CHECK_EN
  logic load_err_q, load_err_d;
`endif

  // Decide whether a load is accepted; without the check every load is taken.
  always_comb begin
`ifdef ACLK_CNT_LOAD_CHECK_EN
    load_ok = bcd_time_valid(new_time_ms_hr, new_time_ls_hr, new_time_ms_min,
                             new_time_ls_min, new_time_ms_sec, new_time_ls_sec,
                             HAS_SECONDS);
`else
    load_ok = 1'b1;
`endif
  end

  // Next-state: load beats hold beats tick; carries ripple sec -> min -> hour.
  always_comb begin
    ms_hr_d    = ms_hr_q;
    ls_hr_d    = ls_hr_q;
    ms_min_d   = ms_min_q;
    ls_min_d   = ls_min_q;
    ms_sec_d   = ms_sec_q;
    ls_sec_d   = ls_sec_q;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;
    min_adv    = 1'b0;
    hr_adv     = 1'b0;
`ifdef ACLK_CNT_LOAD_CHECK_EN
    load_err_d = 1'b0;
`endif
    if (load_new_c) begin
      if (load_ok) begin
        ms_hr_d  = new_time_ms_hr;
        ls_hr_d  = new_time_ls_hr;
        ms_min_d = new_time_ms_min;
        ls_min_d = new_time_ls_min;
        if (HAS_SECONDS) begin
          ms_sec_d = new_time_ms_sec;
          ls_sec_d = new_time_ls_sec;
        end
      end
`ifdef ACLK_CNT_LOAD_CHECK_EN
      load_err_d = !load_ok;
`endif
    end else if (!hold && tick) begin
      if (HAS_SECONDS) begin
        if (ls_sec_q >= MAX_LS) begin
          ls_sec_d = 4'd0;
          if (ms_sec_q >= MAX_MS_MIN) begin
            ms_sec_d = 4'd0;
            min_adv  = 1'b1;
          end else begin
            ms_sec_d = ms_sec_q + 4'd1;
          end
        end else begin
          ls_sec_d = ls_sec_q + 4'd1;
        end
      end else begin
        min_adv = 1'b1;
      end

      if (min_adv) begin
        min_tick_d = 1'b1;
        if (ls_min_q >= MAX_LS) begin
          ls_min_d = 4'd0;
          if (ms_min_q >= MAX_MS_MIN) begin
            ms_min_d = 4'd0;
            hr_adv   = 1'b1;
          end else begin
            ms_min_d = ms_min_q + 4'd1;
          end
        end else begin
          ls_min_d = ls_min_q + 4'd1;
        end
      end

      if (hr_adv) begin
        if (bcd2bin(ms_hr_q, ls_hr_q) >= MAX_HR) begin
          ms_hr_d    = 4'd0;
          ls_hr_d    = 4'd0;
          day_tick_d = 1'b1;
        end else if (ls_hr_q >= MAX_LS) begin
          ls_hr_d = 4'd0;
          ms_hr_d = ms_hr_q + 4'd1;
        end else begin
          ls_hr_d = ls_hr_q + 4'd1;
        end
      end
    end
  end

  // Time and strobe registers; reset lands on the programmed reset time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_hr_q    <= RESET_HR_BCD[7:4];
      ls_hr_q    <= RESET_HR_BCD[3:0];
      ms_min_q   <= RESET_MIN_BCD[7:4];
      ls_min_q   <= RESET_MIN_BCD[3:0];
      ms_sec_q   <= 4'd0;
      ls_sec_q   <= 4'd0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      ms_hr_q    <= ms_hr_d;
      ls_hr_q    <= ls_hr_d;
      ms_min_q   <= ms_min_d;
      ls_min_q   <= ls_min_d;
      ms_sec_q   <= ms_sec_d;
      ls_sec_q   <= ls_sec_d;
      min_tick_q <= min_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

`ifdef ACLK_CNT_LOAD_CHECK_EN
  // Load error flag pulses for one cycle after a rejected load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;
`endif

  assign time_ms_hr  = ms_hr_q;
  assign time_ls_hr  = ls_hr_q;
  assign time_ms_min = ms_min_q;
  assign time_ls_min = ls_min_q;
  assign time_ms_sec = ms_sec_q;
  assign time_ls_sec = ls_sec_q;
  assign min_tick    = min_tick_q;
  assign day_tick    = day_tick_q;

  aclk_hr_fmt u_hr_fmt (
    .ms_hr      (ms_hr_q),
    .ls_hr      (ls_hr_q),
    .mode_12h   (mode_12h),
    .disp_ms_hr (disp_ms_hr),
    .disp_ls_hr (disp_ls_hr),
    .disp_pm    (disp_pm)
  );

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: one instance counting seconds and one
// counting minutes share the same stimulus. A directed vector table covers
// rollover, hold and 12h display; a time-in-seconds reference model checks
// randomized traffic. Honors ACLK_CNT_LOAD_CHECK_EN.
module tb_aclk_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, tick, hold, load_new_c, mode_12h;
  logic [3:0] n_mh, n_lh, n_mm, n_lm, n_ms, n_ls;

  logic [3:0] s_mh, s_lh, s_mm, s_lm, s_ms, s_ls, s_dms, s_dls;
  logic       s_pm, s_min, s_day;
  logic [3:0] m_mh, m_lh, m_mm, m_lm, m_ms, m_ls, m_dms, m_dls;
  logic       m_pm, m_min, m_day;
`ifdef ACLK_CNT_LOAD_CHECK_EN
  logic       s_err, m_err;
`endif

  aclk_time_counter #(.CNT_SECONDS(1), .RESET_HR(7), .RESET_MIN(45)) dut_s (
    .clk(clk), .reset_n(reset_n), .tick(tick), .hold(hold), .load_new_c(load_new_c),
    .new_time_ms_hr(n_mh), .new_time_ls_hr(n_lh), .new_time_ms_min(n_mm),
    .new_time_ls_min(n_lm), .new_time_ms_sec(n_ms), .new_time_ls_sec(n_ls),
    .mode_12h(mode_12h),
    .time_ms_hr(s_mh), .time_ls_hr(s_lh), .time_ms_min(s_mm), .time_ls_min(s_lm),
    .time_ms_sec(s_ms), .time_ls_sec(s_ls),
    .disp_ms_hr(s_dms), .disp_ls_hr(s_dls), .disp_pm(s_pm),
    .min_tick(s_min), .day_tick(s_day)
`ifdef ACLK_CNT_LOAD_CHECK_EN
    , .load_err(s_err)
`endif
  );

  aclk_time_counter #(.CNT_SECONDS(0), .RESET_HR(7), .RESET_MIN(45)) dut_m (
    .clk(clk), .reset_n(reset_n), .tick(tick), .hold(hold), .load_new_c(load_new_c),
    .new_time_ms_hr(n_mh), .new_time_ls_hr(n_lh), .new_time_ms_min(n_mm),
    .new_time_ls_min(n_lm), .new_time_ms_sec(n_ms), .new_time_ls_sec(n_ls),
    .mode_12h(mode_12h),
    .time_ms_hr(m_mh), .time_ls_hr(m_lh), .time_ms_min(m_mm), .time_ls_min(m_lm),
    .time_ms_sec(m_ms), .time_ls_sec(m_ls),
    .disp_ms_hr(m_dms), .disp_ls_hr(m_dls), .disp_pm(m_pm),
    .min_tick(m_min), .day_tick(m_day)
`ifdef ACLK_CNT_LOAD_CHECK_EN
    , .load_err(m_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: seconds-of-day and minutes-of-day plus expected strobes.
  int sec_s, min_m;
  bit exp_s_min, exp_s_day, exp_m_min, exp_m_day, exp_s_err, exp_m_err;

  typedef struct {
    bit          ld, hd, tk, m12;
    logic [23:0] val;
    logic [23:0] exp_time;
    bit          exp_min, exp_day;
    logic [8:0]  exp_disp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] secs_to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [8:0] disp_model(input int h, input bit m12);
    int hh;
    if (!m12) return {1'b0, 4'(h / 10), 4'(h % 10)};
    hh = (h % 12 == 0) ? 12 : h % 12;
    return {(h >= 12), 4'(hh / 10), 4'(hh % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ld, input bit hd, input bit tk, input bit m12,
                               input logic [23:0] val);
    int h, m, s;
    bit ok_s, ok_m;
    load_new_c = ld;
    hold       = hd;
    tick       = tk;
    mode_12h   = m12;
    {n_mh, n_lh, n_mm, n_lm, n_ms, n_ls} = val;
    @(posedge clk);
    exp_s_err = 1'b0;
    exp_m_err = 1'b0;
    exp_s_min = 1'b0;
    exp_s_day = 1'b0;
    exp_m_min = 1'b0;
    exp_m_day = 1'b0;
    if (ld) begin
      h = int'(val[23:20]) * 10 + int'(val[19:16]);
      m = int'(val[15:12]) * 10 + int'(val[11:8]);
      s = int'(val[7:4]) * 10 + int'(val[3:0]);
      ok_m = 1'b1;
      ok_s = 1'b1;
`ifdef ACLK_CNT_LOAD_CHECK_EN
      ok_m = (h <= 23) && (m <= 59) && (val[19:16] <= 9) && (val[11:8] <= 9);
      ok_s = ok_m && (s <= 59) && (val[3:0] <= 9);
`endif
      if (ok_s) sec_s = h * 3600 + m * 60 + s;
      if (ok_m) min_m = h * 60 + m;
      exp_s_err = !ok_s;
      exp_m_err = !ok_m;
    end else if (tk && !hd) begin
      exp_s_min = (sec_s % 60 == 59);
      exp_s_day = (sec_s == 86399);
      sec_s     = (sec_s + 1) % 86400;
      exp_m_min = 1'b1;
      exp_m_day = (min_m == 1439);
      min_m     = (min_m + 1) % 1440;
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " s_time"}, {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, secs_to_bcd(sec_s));
    checkOutput({tag, " s_min_tick"}, s_min, exp_s_min);
    checkOutput({tag, " s_day_tick"}, s_day, exp_s_day);
    checkOutput({tag, " s_disp"}, {s_pm, s_dms, s_dls}, disp_model(sec_s / 3600, mode_12h));
    checkOutput({tag, " m_time"}, {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, secs_to_bcd(min_m * 60));
    checkOutput({tag, " m_min_tick"}, m_min, exp_m_min);
    checkOutput({tag, " m_day_tick"}, m_day, exp_m_day);
    checkOutput({tag, " m_disp"}, {m_pm, m_dms, m_dls}, disp_model(min_m / 60, mode_12h));
`ifdef ACLK_CNT_LOAD_CHECK_EN
    checkOutput({tag, " s_load_err"}, s_err, exp_s_err);
    checkOutput({tag, " m_load_err"}, m_err, exp_m_err);
`endif
  endtask

  task automatic addVec(input bit ld, input bit hd, input bit tk, input bit m12,
                        input logic [23:0] val, input logic [23:0] et,
                        input bit emin, input bit eday, input logic [8:0] edisp);
    vec_t v;
    v.ld = ld; v.hd = hd; v.tk = tk; v.m12 = m12; v.val = val;
    v.exp_time = et; v.exp_min = emin; v.exp_day = eday; v.exp_disp = edisp;
    vecs.push_back(v);
  endtask

  initial begin
    int h, m, s;
    logic [23:0] rv;

    // Directed table for the seconds counter:
    //     ld hd tk 12h value       expected    min day disp{pm,hh}
    addVec(1, 0, 0, 0, 24'h235958, 24'h235958, 0, 0, 9'h023);
    addVec(0, 0, 1, 0, 24'h0,      24'h235959, 0, 0, 9'h023);
    addVec(0, 0, 1, 0, 24'h0,      24'h000000, 1, 1, 9'h000);
    addVec(0, 0, 0, 0, 24'h0,      24'h000000, 0, 0, 9'h000);
    addVec(1, 0, 0, 0, 24'h095959, 24'h095959, 0, 0, 9'h009);
    addVec(0, 0, 1, 0, 24'h0,      24'h100000, 1, 0, 9'h010);
    addVec(1, 0, 0, 0, 24'h101530, 24'h101530, 0, 0, 9'h010);
    for (int i = 0; i < 5; i++)
      addVec(0, 1, 1, 0, 24'h0,    24'h101530, 0, 0, 9'h010);
    addVec(1, 1, 0, 0, 24'h113000, 24'h113000, 0, 0, 9'h011);
    addVec(1, 0, 1, 0, 24'h195959, 24'h195959, 0, 0, 9'h019);
    addVec(0, 0, 1, 0, 24'h0,      24'h200000, 1, 0, 9'h020);
    addVec(0, 0, 1, 0, 24'h0,      24'h200001, 0, 0, 9'h020);
    addVec(0, 0, 1, 0, 24'h0,      24'h200002, 0, 0, 9'h020);
    addVec(1, 0, 0, 1, 24'h000000, 24'h000000, 0, 0, 9'h012);
    addVec(1, 0, 0, 1, 24'h110000, 24'h110000, 0, 0, 9'h011);
    addVec(1, 0, 0, 1, 24'h120000, 24'h120000, 0, 0, 9'h112);
    addVec(1, 0, 0, 1, 24'h130000, 24'h130000, 0, 0, 9'h101);
    addVec(1, 0, 0, 1, 24'h235959, 24'h235959, 0, 0, 9'h111);
    addVec(0, 0, 0, 0, 24'h0,      24'h235959, 0, 0, 9'h023);
    addVec(0, 0, 0, 1, 24'h0,      24'h235959, 0, 0, 9'h111);

    reset_n = 1'b1;
    tick = 1'b0; hold = 1'b0; load_new_c = 1'b0; mode_12h = 1'b0;
    {n_mh, n_lh, n_mm, n_lm, n_ms, n_ls} = 24'h0;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_async s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h074500);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sec_s = 7 * 3600 + 45 * 60;
    min_m = 7 * 60 + 45;
    checkOutput("reset s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h074500);
    checkOutput("reset m_time", {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, 24'h074500);
    checkOutput("reset s_min_tick", s_min, 1'b0);
    checkOutput("reset s_day_tick", s_day, 1'b0);
    checkOutput("reset m_min_tick", m_min, 1'b0);
    checkOutput("reset m_day_tick", m_day, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].hd, vecs[i].tk, vecs[i].m12, vecs[i].val);
      checkOutput($sformatf("vec%0d time", i), {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls},
                  vecs[i].exp_time);
      checkOutput($sformatf("vec%0d min_tick", i), s_min, vecs[i].exp_min);
      checkOutput($sformatf("vec%0d day_tick", i), s_day, vecs[i].exp_day);
      checkOutput($sformatf("vec%0d disp", i), {s_pm, s_dms, s_dls}, vecs[i].exp_disp);
      checkOutput($sformatf("vec%0d m_time", i), {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls},
                  secs_to_bcd(min_m * 60));
      checkOutput($sformatf("vec%0d m_min_tick", i), m_min, exp_m_min);
      checkOutput($sformatf("vec%0d m_day_tick", i), m_day, exp_m_day);
    end

    // Minute-counter carry into the hour, as seen by the minute instance.
    applyStimulus(1, 0, 0, 0, 24'h095900);
    applyStimulus(0, 0, 1, 0, 24'h0);
    checkOutput("min_cnt 09:59 tick", {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, 24'h100000);
    checkOutput("min_cnt 09:59 min_tick", m_min, 1'b1);

`ifdef ACLK_CNT_LOAD_CHECK_EN
    applyStimulus(1, 0, 0, 0, 24'h120000);
    checkModel("pre_bad");
    applyStimulus(1, 0, 0, 0, 24'h240000);
    checkOutput("bad_load s_err", s_err, 1'b1);
    checkOutput("bad_load s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h120000);
    checkModel("bad_load");
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkModel("bad_load_after");
    applyStimulus(1, 0, 0, 0, 24'h123456);
    checkOutput("good_load s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h123456);
    checkModel("good_load");
`else
    applyStimulus(1, 0, 0, 0, 24'h069959);
    checkOutput("odd_load s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h069959);
    checkOutput("odd_load m_time", {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, 24'h069900);
    applyStimulus(0, 0, 1, 0, 24'h0);
    checkOutput("odd_recover s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h070000);
    checkOutput("odd_recover m_time", {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, 24'h070000);
    checkOutput("odd_recover s_min_tick", s_min, 1'b1);
    checkOutput("odd_recover m_min_tick", m_min, 1'b1);
    sec_s = 7 * 3600;
    min_m = 7 * 60;
`endif

    // Randomized traffic biased toward rollover points.
    for (int n = 0; n < 400; n++) begin
      h = int'($urandom_range(0, 23));
      m = ($urandom % 2 == 0) ? 59 : int'($urandom_range(0, 59));
      s = ($urandom % 2 == 0) ? int'($urandom_range(55, 59)) : int'($urandom_range(0, 59));
      rv = secs_to_bcd(h * 3600 + m * 60 + s);
      applyStimulus(($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0,
                    ($urandom % 2) == 1, rv);
      checkModel($sformatf("rand%0d", n));
    end

    // Asynchronous reset between clock edges.
    tick = 1'b0; load_new_c = 1'b0; hold = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset s_time", {s_mh, s_lh, s_mm, s_lm, s_ms, s_ls}, 24'h074500);
    checkOutput("async_reset m_time", {m_mh, m_lh, m_mm, m_lm, m_ms, m_ls}, 24'h074500);
    checkOutput("async_reset s_min_tick", s_min, 1'b0);
    checkOutput("async_reset s_day_tick", s_day, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
